atr_sequencer: RTL and testbench

Per-channel timing controller that produces the `tx`/`rx` automatic-transmit-receive state driving the GPIO ATR bank.
- Takes raw transmit and receive run requests from the DSP chains.
- Applies programmable turn-on and turn-off delays per channel, such as PA warm-up lead or LNA settling after TX.
- Optionally enforces half-duplex and exposes a software force mode.
- Configured over the standard settings bus; sits between the DSP run flags and the GPIO ATR block.

---
 rtl/atr_seq_pkg.sv | 23 ++
 rtl/atr_delay_chan.sv | 79 +++++++
 rtl/atr_sequencer.sv | 88 ++++++++
 tb/tb_atr_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/atr_seq_pkg.sv
// Shared definitions for the ATR sequencer: channel state encoding,
// settings-bus register offsets and control-register bit positions.
package atr_seq_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_ON_WAIT  = 2'd1,
    ST_ON       = 2'd2,
    ST_OFF_WAIT = 2'd3
  } chan_state_t;

  localparam int REG_TX   = 0;
  localparam int REG_RX   = 1;
  localparam int REG_CTRL = 2;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_HALF_DUPLEX = 1;
  localparam int CTRL_FORCE       = 2;
  localparam int CTRL_FORCE_RX    = 3;
  localparam int CTRL_FORCE_TX    = 4;
  localparam int CTRL_W           = 5;

endpackage

// File: rtl/atr_delay_chan.sv
// One ATR channel: turn-on/turn-off delay FSM with a 16-bit down-counter.
// Delays are latched into the counter at the moment a wait begins.
module atr_delay_chan
  import atr_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [15:0] on_dly,
  input  logic [15:0] off_dly,
  input  logic        hold,
  output logic        out,
  output chan_state_t state
);

  chan_state_t state_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_OFF;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // NOTE: every output of this block is given a default first; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (hold) begin
      state_n = ST_OFF;
    end else begin
      unique case (state)
        ST_OFF: begin
          if (req) begin
            if (on_dly == 16'd0) begin
              state_n = ST_ON;
            end else begin
              cnt_n   = on_dly - 16'd1;
              state_n = ST_ON_WAIT;
            end
          end
        end
        ST_ON_WAIT: begin
          if (!req)                state_n = ST_OFF;
          else if (cnt == 16'd0)   state_n = ST_ON;
          else                     cnt_n   = cnt - 16'd1;
        end
        ST_ON: begin
          if (!req) begin
            if (off_dly == 16'd0) begin
              state_n = ST_OFF;
            end else begin
              cnt_n   = off_dly - 16'd1;
              state_n = ST_OFF_WAIT;
            end
          end
        end
        ST_OFF_WAIT: begin
          // Re-arming goes straight back to ON, so the output never dips.
          if (req)                 state_n = ST_ON;
          else if (cnt == 16'd0)   state_n = ST_OFF;
          else                     cnt_n   = cnt - 16'd1;
        end
        default: state_n = ST_OFF;
      endcase
    end
  end

  assign out = (state == ST_ON) || (state == ST_OFF_WAIT);

endmodule

// File: rtl/atr_sequencer.sv
// ATR sequencer top: settings-bus registers, half-duplex gating of the RX
// request, force override and status packing around two delay channels.
module atr_sequencer
  import atr_seq_pkg::*;
#(
  parameter int BASE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        tx_req,
  input  logic        rx_req,
  output logic        atr_tx,
  output logic        atr_rx,
  output logic [31:0] status
);

  localparam logic [7:0] ADDR_TX   = 8'(BASE + REG_TX);
  localparam logic [7:0] ADDR_RX   = 8'(BASE + REG_RX);
  localparam logic [7:0] ADDR_CTRL = 8'(BASE + REG_CTRL);

  logic [15:0]       tx_on_dly, tx_off_dly, rx_on_dly, rx_off_dly;
  logic [CTRL_W-1:0] ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_on_dly  <= '0;
      tx_off_dly <= '0;
      rx_on_dly  <= '0;
      rx_off_dly <= '0;
      ctrl       <= '0;
    end else if (set_stb) begin
      if (set_addr == ADDR_TX) begin
        tx_on_dly  <= set_data[15:0];
        tx_off_dly <= set_data[31:16];
      end
      if (set_addr == ADDR_RX) begin
        rx_on_dly  <= set_data[15:0];
        rx_off_dly <= set_data[31:16];
      end
      if (set_addr == ADDR_CTRL) ctrl <= set_data[CTRL_W-1:0];
    end
  end

  logic        enable, half_duplex, force_en;
  logic        hold, rx_req_eff;
  logic        tx_out, rx_out;
  chan_state_t tx_state, rx_state;

  assign enable      = ctrl[CTRL_ENABLE];
  assign half_duplex = ctrl[CTRL_HALF_DUPLEX];
  assign force_en    = ctrl[CTRL_FORCE];
  assign hold        = force_en | ~enable;

  // RX is locked out until TX has fully returned to OFF, not just dropped req.
  assign rx_req_eff = rx_req & ~(half_duplex & (tx_req | (tx_state != ST_OFF)));

  atr_delay_chan u_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (tx_req),
    .on_dly  (tx_on_dly),
    .off_dly (tx_off_dly),
    .hold    (hold),
    .out     (tx_out),
    .state   (tx_state)
  );

  atr_delay_chan u_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (rx_req_eff),
    .on_dly  (rx_on_dly),
    .off_dly (rx_off_dly),
    .hold    (hold),
    .out     (rx_out),
    .state   (rx_state)
  );

  // Driven only from flops, so no input reaches the ATR bank combinationally.
  assign atr_tx = force_en ? ctrl[CTRL_FORCE_TX] : (enable & tx_out);
  assign atr_rx = force_en ? ctrl[CTRL_FORCE_RX] : (enable & rx_out);

  assign status = {26'd0, atr_rx, atr_tx, rx_state, tx_state};

endmodule

// File: tb/tb_atr_sequencer.sv
// Directed bench for atr_sequencer: expected status words are queued as the
// stimulus is set up and popped against the DUT one per clock.
module tb_atr_sequencer;
  import atr_seq_pkg::*;

  localparam int BASE = 8'h20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        tx_req = 1'b0;
  logic        rx_req = 1'b0;
  logic        atr_tx, atr_rx;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_item_t;

  sb_item_t sb_q[$];

  atr_sequencer #(.BASE(BASE)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .tx_req   (tx_req),
    .rx_req   (rx_req),
    .atr_tx   (atr_tx),
    .atr_rx   (atr_rx),
    .status   (status)
  );

  always #5 clk = ~clk;

  function automatic logic is_on(logic [1:0] s);
    return (s == ST_ON) || (s == ST_OFF_WAIT);
  endfunction

  // Expected status word; the ATR bits follow the channel states.
  function automatic logic [31:0] stat(logic [1:0] t, logic [1:0] r);
    return {26'd0, is_on(r), is_on(t), r, t};
  endfunction

  task automatic push(input string tag, input logic [31:0] exp,
                      input logic [31:0] mask = 32'hFFFF_FFFF);
    sb_item_t it;
    it.tag  = tag;
    it.exp  = exp;
    it.mask = mask;
    sb_q.push_back(it);
  endtask

  task automatic check();
    sb_item_t it;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: status=%h with no expected entry", status);
    end else begin
      it = sb_q.pop_front();
      assert ((status & it.mask) === (it.exp & it.mask)) else begin
        errors++;
        $error("FAIL %s: status=%h expected %h (mask %h)",
               it.tag, status, it.exp, it.mask);
      end
      assert (atr_tx === status[4] && atr_rx === status[5]) else begin
        errors++;
        $error("FAIL %s_pins: atr_tx=%b atr_rx=%b expected status bits %b %b",
               it.tag, atr_tx, atr_rx, status[4], status[5]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int off, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = 8'(BASE + off);
    set_data = data;
    tick();
    set_stb  = 1'b0;
  endtask

  initial begin
    logic [1:0] ts, rs;

    // Reset state.
    tick();
    push("reset", 32'd0);
    check();
    reset_n = 1'b1;
    tick();
    push("post_reset", 32'd0);
    check();

    // TX on/off timing: on_dly=5, off_dly=3, request for 20 cycles.
    write(REG_CTRL, 32'h1);
    write(REG_TX, {16'd3, 16'd5});
    for (int i = 1; i <= 28; i++) begin
      ts = (i <= 5) ? ST_ON_WAIT : (i <= 20) ? ST_ON : (i <= 23) ? ST_OFF_WAIT : ST_OFF;
      push("tx_on_off", stat(ts, ST_OFF));
    end
    tx_req = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      tick();
      check();
      if (i == 20) tx_req = 1'b0;
    end

    // RX request shorter than on_dly: aborts, output never pulses.
    write(REG_RX, {16'd2, 16'd10});
    for (int i = 1; i <= 8; i++) begin
      rs = (i <= 4) ? ST_ON_WAIT : ST_OFF;
      push("rx_abort", stat(ST_OFF, rs));
    end
    rx_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check();
      if (i == 4) rx_req = 1'b0;
    end

    // TX re-arm during OFF_WAIT with off_dly=8, then a full turn-off.
    write(REG_TX, {16'd8, 16'd5});
    for (int i = 1; i <= 26; i++) begin
      ts = (i <= 5)  ? ST_ON_WAIT : (i <= 10) ? ST_ON : (i <= 13) ? ST_OFF_WAIT :
           (i <= 16) ? ST_ON : (i <= 24) ? ST_OFF_WAIT : ST_OFF;
      push("tx_rearm", stat(ts, ST_OFF));
    end
    tx_req = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      tick();
      check();
      if (i == 10) tx_req = 1'b0;
      if (i == 13) tx_req = 1'b1;
      if (i == 16) tx_req = 1'b0;
    end

    // Half-duplex: TX pre-empts RX; RX restarts only once TX is back in OFF.
    write(REG_CTRL, 32'h3);
    write(REG_TX, {16'd1, 16'd2});
    write(REG_RX, {16'd2, 16'd2});
    for (int i = 1; i <= 16; i++) begin
      ts = (i <= 5) ? ST_OFF : (i <= 7) ? ST_ON_WAIT : (i <= 10) ? ST_ON :
           (i == 11) ? ST_OFF_WAIT : ST_OFF;
      rs = (i <= 2) ? ST_ON_WAIT : (i <= 5) ? ST_ON : (i <= 7) ? ST_OFF_WAIT :
           (i <= 12) ? ST_OFF : (i <= 14) ? ST_ON_WAIT : ST_ON;
      push("half_duplex", stat(ts, rs));
    end
    rx_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check();
      if (i == 5)  tx_req = 1'b1;
      if (i == 10) tx_req = 1'b0;
    end

    // Force with enable=0 overrides outputs and holds both FSMs in OFF.
    write(REG_CTRL, 32'h14);
    push("force_pins", 32'h10, 32'h30);
    check();
    tick();
    push("force_hold", 32'h10);
    check();
    write(REG_CTRL, 32'h0);
    push("unforce_pins", 32'h0, 32'h30);
    check();
    tick();
    push("disabled_hold", 32'h0);
    check();
    rx_req = 1'b0;

    // Reset in the middle of a long ON_WAIT.
    write(REG_CTRL, 32'h1);
    write(REG_TX, {16'd0, 16'd100});
    tx_req = 1'b1;
    tick();
    tick();
    tick();
    push("long_wait", stat(ST_ON_WAIT, ST_OFF));
    check();
    reset_n = 1'b0;
    #1;
    push("async_reset", 32'd0);
    check();
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) push("stay_off", 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check();
    end

    // Unmapped address is ignored; the real control write re-enables with
    // the reset (zero) delays.
    write(3, 32'h1);
    tick();
    push("unmapped_addr", 32'd0);
    check();
    write(REG_CTRL, 32'h1);
    push("reenable_edge", 32'd0);
    check();
    tick();
    push("zero_on_dly", stat(ST_ON, ST_OFF));
    check();
    tx_req = 1'b0;
    tick();
    push("zero_off_dly", 32'd0);
    check();

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
